// File: rtl/genius_btn_encoder.sv
// Purpose: player-side button front end for the Genius game. It synchronises and debounces
//          the three raw buttons, rejects chords, and emits one 2-bit code per physical press.
// Latency: a clean press raises press_valid DEBOUNCE_CYCLES+3 edges after the first edge
//          that samples it. press_ready in the same cycle as press_valid accepts it at the next edge.
// Backpressure: the press is held in EMIT with code frozen until press_ready.
//          No second press is taken until release has been stable.
// Ports:
//   clock, reset (sync, active-low) | btn[2:0] raw buttons, btn[i] -> code i
//   enable: accept new presses | press_ready: consumer takes press_code this cycle
//   press_valid/press_code: offered press (3 = chord) | busy: FSM not in IDLE
module genius_btn_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       enable,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [1:0] press_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_EMIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       POL     = BTN_ACTIVE_LOW ? 3'b111 : 3'b000;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_lp;
    logic [2:0]       w_lp_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [1:0]       r_code;
    logic [1:0]       w_code_nxt;
    logic [2:0]       w_btn_norm;
    logic [2:0]       w_p;
    logic             w_same;
    logic             w_stable;
    logic [1:0]       w_lp_code;

    // Polarity is normalised ahead of the synchroniser.
    // An all-zero reset value then means "released" regardless of board polarity.
    assign w_btn_norm = btn ^ POL;
    assign w_p        = r_sync2;

    assign w_same    = (w_p == r_lp);
    assign w_stable  = w_same && (r_cnt == CNT_MAX);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Single button -> its index; anything else that got latched is a chord.
    always_comb begin
        w_lp_code = 2'd3;
        case (r_lp)
            3'b001:  w_lp_code = 2'd0;
            3'b010:  w_lp_code = 2'd1;
            3'b100:  w_lp_code = 2'd2;
            default: w_lp_code = 2'd3;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lp_nxt    = r_lp;
        w_cnt_nxt   = w_same ? w_cnt_inc : '0;
        w_valid_nxt = r_valid;
        w_code_nxt  = r_code;
        case (r_state)
            S_IDLE: begin
                if (enable && (w_p != 3'b000)) begin
                    w_lp_nxt    = w_p;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (w_p == 3'b000) begin
                    // Bounce back to released before the level was accepted.
                    w_lp_nxt    = 3'b000;
                    w_state_nxt = S_IDLE;
                end else if (!w_same) begin
                    // Pattern changed (e.g. chord forming): debounce the new pattern.
                    w_lp_nxt  = w_p;
                    w_cnt_nxt = '0;
                end else if (!enable) begin
                    // The game stopped listening, so drop the press.
                    // It must still be released before the next press.
                    w_lp_nxt    = 3'b000;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else if (w_stable) begin
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = w_lp_code;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (press_ready) begin
                    w_valid_nxt = 1'b0;
                    w_lp_nxt    = 3'b000;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // lp is zero here, so "stable" means released for the full debounce window.
                if (w_stable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_lp    <= 3'b000;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_code  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= w_btn_norm;
            r_sync2 <= r_sync1;
            r_lp    <= w_lp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign press_valid = r_valid;
    assign press_code  = r_code;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_genius_btn_encoder.sv
module tb_genius_btn_encoder;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] btn = 3'b111;
    logic       enable = 1'b1;
    logic       press_ready = 1'b0;
    logic       press_valid;
    logic [1:0] press_code;
    logic       busy;

    genius_btn_encoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn(btn),
        .enable(enable),
        .press_ready(press_ready),
        .press_valid(press_valid),
        .press_code(press_code),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model. It tracks the player at the level of "what has been pressed
    // and for how long", not the RTL registers.
    // A press is offered once the same non-zero pattern has been seen on D+1
    // consecutive samples, counted from when an enabled, armed encoder first saw it.
    // After it is taken, or abandoned because enable dropped, D zero samples re-arm it.
    localparam int PH_ARMED   = 0;
    localparam int PH_CAND    = 1;
    localparam int PH_OFFERED = 2;
    localparam int PH_REARM   = 3;

    int         m_phase = PH_ARMED;
    int         m_seen = 0;
    int         m_zeros = 0;
    logic [2:0] m_cand = 3'b000;
    logic [2:0] m_s1 = 3'b000;
    logic [2:0] m_s2 = 3'b000;
    logic [1:0] m_code = 2'd0;
    logic       m_valid;
    logic       m_busy;

    function automatic logic [1:0] code_of(input logic [2:0] pat);
        if ($countones(pat) != 1) return 2'd3;
        for (int i = 0; i < 3; i++) if (pat[i]) return 2'(i);
        return 2'd3;
    endfunction

    always @(posedge clock) begin
        logic [2:0] p;
        exp_t e;
        cyc = cyc + 1;
        if (!reset) begin
            m_phase = PH_ARMED;
            m_s1 = 3'b000;
            m_s2 = 3'b000;
            m_code = 2'd0;
        end else begin
            p = m_s2;
            case (m_phase)
                PH_ARMED: if (enable && p != 3'b000) begin
                    m_cand = p; m_seen = 1; m_phase = PH_CAND;
                end
                PH_CAND: begin
                    if (p == 3'b000) m_phase = PH_ARMED;
                    else if (p != m_cand) begin m_cand = p; m_seen = 1; end
                    else if (!enable) begin m_phase = PH_REARM; m_zeros = 0; end
                    else begin
                        m_seen++;
                        if (m_seen == D + 1) begin
                            m_phase = PH_OFFERED;
                            m_code = code_of(m_cand);
                            e.code = m_code;
                            e.cyc = cyc;
                            sb_q.push_back(e);
                        end
                    end
                end
                PH_OFFERED: if (press_ready) begin m_phase = PH_REARM; m_zeros = 0; end
                default: begin
                    if (p == 3'b000) begin
                        m_zeros++;
                        if (m_zeros == D) m_phase = PH_ARMED;
                    end else m_zeros = 0;
                end
            endcase
            m_s2 = m_s1;
            m_s1 = ~btn;
        end
        m_valid = (m_phase == PH_OFFERED);
        m_busy = (m_phase != PH_ARMED);
    end

    // Monitor. Each new offer pops the scoreboard; every cycle the handshake outputs
    // are compared against the model.
    logic prev_valid = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (chk_on) begin
            if (press_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_press", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("press_code", int'(press_code), int'(e.code));
                    chk("press_cycle", cyc, e.cyc);
                end
            end
            chk("valid", int'(press_valid), int'(m_valid));
            chk("busy", int'(busy), int'(m_busy));
            if (m_valid) chk("held_code", int'(press_code), int'(m_code));
        end
        prev_valid = press_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive a pressed mask (1 = pressed) onto the active-low buttons.
    task automatic hold(input logic [2:0] pressed, input int n);
        btn = ~pressed;
        step(n);
    endtask

    initial begin
        logic [2:0] pat;
        int dur;
        int r;
        step(3);
        chk_on = 1'b1;
        chk("rst_valid", int'(press_valid), 0);
        chk("rst_code", int'(press_code), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;

        // Single button 0 with the consumer always ready. There must be one pulse only while it is held.
        press_ready = 1'b1;
        hold(3'b001, 20);
        hold(3'b000, 10);

        // Button 1 bounces before settling, and the consumer stalls.
        press_ready = 1'b0;
        hold(3'b010, 2);
        hold(3'b000, 1);
        hold(3'b010, 15);
        press_ready = 1'b1;
        step(1);
        press_ready = 1'b0;
        hold(3'b010, 3);
        hold(3'b000, 10);

        // Chord of buttons 0 and 1, then a short tap that never debounces.
        press_ready = 1'b1;
        hold(3'b011, 12);
        hold(3'b000, 8);
        hold(3'b100, 3);
        hold(3'b000, 8);

        // While disabled, a held button is ignored until enable rises.
        enable = 1'b0;
        hold(3'b100, 10);
        chk("disabled_busy", int'(busy), 0);
        enable = 1'b1;
        hold(3'b100, 12);
        hold(3'b000, 10);

        // The release is interrupted by a quick re-press, so the re-arm window restarts.
        hold(3'b001, 12);
        hold(3'b000, 2);
        hold(3'b001, 10);
        hold(3'b000, 10);
        hold(3'b001, 12);
        hold(3'b000, 10);

        // Reset lands while a press is offered, with the consumer ready in the same cycle.
        press_ready = 1'b0;
        hold(3'b100, 12);
        reset = 1'b0;
        press_ready = 1'b1;
        step(1);
        chk("emit_rst_valid", int'(press_valid), 0);
        chk("emit_rst_code", int'(press_code), 0);
        chk("emit_rst_busy", int'(busy), 0);
        reset = 1'b1;
        hold(3'b100, 12);
        hold(3'b000, 10);

        // Random traffic with random enable, ready, chords and occasional resets.
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 9);
            if (r < 4) pat = 3'b000;
            else if (r < 9) pat = 3'b001 << $urandom_range(0, 2);
            else pat = 3'($urandom_range(1, 7));
            dur = $urandom_range(1, 9);
            enable = ($urandom_range(0, 9) != 0);
            btn = ~pat;
            for (int c = 0; c < dur; c++) begin
                press_ready = ($urandom_range(0, 2) != 0);
                reset = ($urandom_range(0, 199) != 0);
                step(1);
            end
            reset = 1'b1;
        end

        enable = 1'b1;
        press_ready = 1'b1;
        hold(3'b000, 20);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
